// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline stage register with valid/ready handshake, two-entry skid
// buffer, synchronous flush and a saturating backpressure (stall) counter.
module pipe_stage_skid #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned CLEAR_ON_FLUSH = 1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            if (CLEAR_ON_FLUSH != 0) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_valid) begin
                        state_d = BUSY;
                        main_d  = in_data;
                    end
                end
                BUSY: begin
                    if (in_valid && out_ready) begin
                        main_d = in_data;
                    end else if (in_valid) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (out_ready) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // Skid entry drains into main; in_ready is low so no new input here.
                    if (out_ready) begin
                        state_d = BUSY;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Counter ignores flush: a backpressured flush cycle still counts.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_valid && !out_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != FULL);
    assign out_data  = main_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid: streaming, skid backpressure,
// flush, counter saturation/clear and asynchronous reset.
module tb_pipe_stage_skid;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 3;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             cnt_clr;
    logic [CNT_W-1:0] stall_cnt;

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    pipe_stage_skid #(
        .WIDTH(WIDTH),
        .CLEAR_ON_FLUSH(1),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .cnt_clr(cnt_clr),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; cnt_clr = 1'b0;

        // Reset state
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_data",  out_data,       32'h0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        #5 reset = 1'b1;

        // Streaming 1,2,3 with out_ready high
        in_valid = 1'b1; out_ready = 1'b1; in_data = 32'h1;
        tick();
        chk("str1_valid", 32'(out_valid), 32'd1);
        chk("str1_data",  out_data,       32'h1);
        chk("str1_ready", 32'(in_ready),  32'd1);
        in_data = 32'h2;
        tick();
        chk("str2_valid", 32'(out_valid), 32'd1);
        chk("str2_data",  out_data,       32'h2);
        in_data = 32'h3;
        tick();
        chk("str3_valid", 32'(out_valid), 32'd1);
        chk("str3_data",  out_data,       32'h3);
        in_valid = 1'b0;
        tick();
        chk("str_drain_valid", 32'(out_valid), 32'd0);
        chk("str_stall_cnt",   32'(stall_cnt), 32'd0);

        // Backpressure into the skid register
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        tick();
        chk("bp_a_data",  out_data,       32'hA);
        chk("bp_a_ready", 32'(in_ready),  32'd1);
        chk("bp_a_cnt",   32'(stall_cnt), 32'd0);
        in_data = 32'hB;
        tick();
        chk("bp_full_ready", 32'(in_ready),  32'd0);
        chk("bp_full_data",  out_data,       32'hA);
        chk("bp_full_cnt",   32'(stall_cnt), 32'd1);
        in_valid = 1'b0;
        repeat (4) tick();
        chk("bp_hold_cnt",  32'(stall_cnt), 32'd5);
        chk("bp_hold_data", out_data,       32'hA);
        out_ready = 1'b1;
        tick();
        chk("bp_b_data",  out_data,       32'hB);
        chk("bp_b_valid", 32'(out_valid), 32'd1);
        chk("bp_b_ready", 32'(in_ready),  32'd1);
        tick();
        chk("bp_drain_valid", 32'(out_valid), 32'd0);
        chk("bp_final_cnt",   32'(stall_cnt), 32'd5);

        cnt_clr = 1'b1;
        tick();
        chk("clr_cnt", 32'(stall_cnt), 32'd0);
        cnt_clr = 1'b0;

        // Flush while FULL with a payload offered in the flush cycle
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        chk("fl_pre_ready", 32'(in_ready), 32'd0);
        flush = 1'b1; in_data = 32'hC;
        tick();
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_ready", 32'(in_ready),  32'd1);
        chk("fl_data",  out_data,       32'h0);
        chk("fl_cnt",   32'(stall_cnt), 32'd2);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("fl_no_c_valid", 32'(out_valid), 32'd0);

        // Counter saturation at 2^CNT_W-1
        in_valid = 1'b1; in_data = 32'hD;
        tick();
        chk("sat_start_cnt", 32'(stall_cnt), 32'd2);
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("sat_cnt", 32'(stall_cnt), (i + 3 > 7) ? 32'd7 : 32'(i + 3));
        end
        chk("sat_data", out_data, 32'hD);

        // Simultaneous flush + cnt_clr
        flush = 1'b1; cnt_clr = 1'b1;
        tick();
        chk("flclr_valid", 32'(out_valid), 32'd0);
        chk("flclr_cnt",   32'(stall_cnt), 32'd0);
        flush = 1'b0; cnt_clr = 1'b0;

        // Asynchronous reset while FULL
        in_valid = 1'b1; in_data = 32'hE;
        tick();
        in_data = 32'hF;
        tick();
        chk("ar_pre_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        #3 reset = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_data",  out_data,       32'h0);
        chk("ar_ready", 32'(in_ready),  32'd1);
        chk("ar_cnt",   32'(stall_cnt), 32'd0);
        in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b1;
        tick();
        chk("ar_held_valid", 32'(out_valid), 32'd0);
        #3 reset = 1'b1;
        in_data = 32'h55;
        tick();
        chk("ar_rel_valid", 32'(out_valid), 32'd1);
        chk("ar_rel_data",  out_data,       32'h55);
        in_valid = 1'b0;
        tick();
        chk("ar_rel_drain", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register that generalises the fixed execute/memory flip-flop. It carries a WIDTH-bit payload between any two pipeline stages and adds a valid/ready handshake with a two-entry skid buffer, so backpressure never drops data. It also has a synchronous flush with optional payload clearing and a saturating stall counter for performance monitoring. It is instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB with per-site parameters.

## Interface
- WIDTH, 32: payload width in bits (≥1).
- CLEAR_ON_FLUSH, 1: 1 = flush zeroes both payload registers; 0 = flush clears only valid state.
- CNT_W, 16: stall counter width (≥1).

- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept a payload this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  downstream payload valid.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  downstream payload.
- cnt_clr  input  1  synchronous clear of stall_cnt.
- stall_cnt  output  CNT_W  saturating count of backpressured cycles.

## Operation
- Storage: main register (drives out_data), skid register, and a 2-bit state: EMPTY, BUSY (main holds data), FULL (main and skid hold data).
- out_valid = (state != EMPTY). in_ready = (state != FULL). Both are decoded from registered state only, with no combinational in→out path.
- An upstream transfer happens when in_valid & in_ready. A downstream transfer happens when out_valid & out_ready.
- Transitions when flush = 0:
  - EMPTY: in_valid → BUSY, main ← in_data. Otherwise stay.
  - BUSY: in_valid & out_ready → BUSY, main ← in_data. in_valid & !out_ready → FULL, skid ← in_data. !in_valid & out_ready → EMPTY. Otherwise hold.
  - FULL: out_ready → BUSY, main ← skid. Otherwise hold. in_valid is ignored because in_ready = 0.
- Flush has priority over all transitions. Next state is EMPTY.
  - A payload offered in the flush cycle is discarded. Upstream still sees in_ready per the current state.
  - A downstream transfer in the flush cycle still completes, because out_data is valid that cycle.
  - With CLEAR_ON_FLUSH = 1, main and skid ← 0. With CLEAR_ON_FLUSH = 0, they keep their contents, which are don't-care while invalid.
- Payload ordering is strictly FIFO. The skid entry is never overtaken by a new input.
- stall_cnt increments by 1 each cycle with out_valid & !out_ready and saturates at 2^CNT_W−1.
  - cnt_clr loads 0 and wins over an increment in the same cycle.
  - flush does not affect stall_cnt.
  - A flush cycle with out_valid & !out_ready still counts.

## Timing
- Reset asserted (reset = 0), taking effect immediately without a clock edge:
  - state = EMPTY, main = 0, skid = 0, stall_cnt = 0.
  - Outputs during reset: out_valid = 0, out_data = 0, in_ready = 1. Transfers are ignored while reset is asserted.
- Deassertion is synchronised externally. The first active edge follows the first rising clk with reset = 1.
- Latency: a payload accepted at edge N appears on out_data with out_valid = 1 after edge N, so it is valid in cycle N+1.
- Throughput: 1 payload per cycle sustained while out_ready = 1.
- in_ready falls one cycle after the first backpressured accept (BUSY→FULL). It rises one cycle after the downstream drains (FULL→BUSY).
- Reset mid-FULL: both entries are lost and no output is produced after release.
- Simultaneous flush + cnt_clr: both act, giving state EMPTY and stall_cnt = 0.

## Test plan
- Streaming: WIDTH = 32, out_ready = 1, inputs 0x1, 0x2, 0x3 on consecutive cycles → out_data 0x1, 0x2, 0x3 one cycle later each, with out_valid = 1 for 3 cycles and stall_cnt = 0.
- Backpressure/skid: send 0xA, 0xB with out_ready = 0, then hold 4 cycles and raise out_ready → in_ready = 0 after 0xB is taken. Outputs are 0xA then 0xB in order with no loss, and stall_cnt = 5 (cycles with out_valid & !out_ready).
- Flush in FULL: state FULL holding 0xA/0xB, flush = 1 with in_valid = 1 and in_data = 0xC → next cycle out_valid = 0, in_ready = 1, and 0xC never appears. With CLEAR_ON_FLUSH = 1, out_data = 0.
- Saturation: CNT_W = 3, hold out_valid = 1 and out_ready = 0 for 10 cycles → stall_cnt stops at 7. Pulse cnt_clr → 0 next cycle.
- Async reset: assert reset = 0 between clock edges while FULL → out_valid = 0 and out_data = 0 immediately. After release, the first accepted input 0x55 appears one cycle later.
